vote_display_ctrl: RTL and testbench

Parametrised display and mode controller for the voting machine. Sits between the vote-counter bank and the LED bank. Generalises the single-width, four-candidate controller with:
- any candidate count and counter width;
- a retriggerable vote-acknowledge flash;
- an auto-scan result mode;
- a sequential winner/tie search mode.

---
 rtl/vote_pkg.sv | 15 +
 rtl/winner_scan.sv | 79 +++++++
 rtl/vote_display_ctrl.sv | 158 +++++++++++++++
 tb/tb_vote_display_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the voting machine display controller:
// mode encodings and the tie highlight pattern.
package vote_pkg;

    typedef enum logic [1:0] {
        MODE_VOTING = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_WINNER = 2'd3
    } mode_e;

    localparam logic [7:0] TIE_PATTERN = 8'hAA;
    localparam int         TMR_W       = 32;

endpackage

// File: rtl/winner_scan.sv
// Sequential winner/tie search: examines one candidate per clock and
// latches the lowest-index maximum and a tie flag at the end of each pass.
module winner_scan #(
    parameter int N_CAND = 4,
    parameter int VOTE_W = 8,
    parameter int IDX_W  = $clog2(N_CAND)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_CAND*VOTE_W-1:0]   vote_counts,
    output logic [IDX_W-1:0]           winner_idx,
    output logic                       tie,
    output logic                       winner_valid
);

    logic [VOTE_W-1:0] cnt_s [N_CAND];
    logic [IDX_W-1:0]  pass_cnt_r;
    logic [VOTE_W-1:0] max_r;
    logic [IDX_W-1:0]  max_idx_r;
    logic              dup_r;
    logic [VOTE_W-1:0] cand_s;
    logic [VOTE_W-1:0] max_nxt_s;
    logic [IDX_W-1:0]  max_idx_nxt_s;
    logic              dup_nxt_s;
    logic              last_s;

    genvar g;
    generate
        for (g = 0; g < N_CAND; g++) begin : g_unpack
            assign cnt_s[g] = vote_counts[g*VOTE_W +: VOTE_W];
        end
    endgenerate

    // Running max update for the candidate under examination this cycle.
    always_comb begin
        cand_s        = cnt_s[pass_cnt_r];
        last_s        = (pass_cnt_r == IDX_W'(N_CAND - 1));
        max_nxt_s     = max_r;
        max_idx_nxt_s = max_idx_r;
        dup_nxt_s     = dup_r;
        if (pass_cnt_r == {IDX_W{1'b0}}) begin
            max_nxt_s     = cand_s;
            max_idx_nxt_s = pass_cnt_r;
            dup_nxt_s     = 1'b0;
        end else if (cand_s > max_r) begin
            max_nxt_s     = cand_s;
            max_idx_nxt_s = pass_cnt_r;
            dup_nxt_s     = 1'b0;
        end else if ((cand_s == max_r) && (max_r != {VOTE_W{1'b0}})) begin
            dup_nxt_s     = 1'b1;
        end else begin
            dup_nxt_s     = dup_r;
        end
    end

    // Pass counter, running registers and end-of-pass result latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass_cnt_r   <= {IDX_W{1'b0}};
            max_r        <= {VOTE_W{1'b0}};
            max_idx_r    <= {IDX_W{1'b0}};
            dup_r        <= 1'b0;
            winner_idx   <= {IDX_W{1'b0}};
            tie          <= 1'b0;
            winner_valid <= 1'b0;
        end else begin
            pass_cnt_r <= last_s ? {IDX_W{1'b0}} : pass_cnt_r + IDX_W'(1);
            max_r      <= max_nxt_s;
            max_idx_r  <= max_idx_nxt_s;
            dup_r      <= dup_nxt_s;
            if (last_s) begin
                winner_idx   <= max_idx_nxt_s;
                tie          <= dup_nxt_s;
                winner_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vote_display_ctrl.sv
// Display and mode controller between the vote-counter bank and the LEDs:
// acknowledge flash, manual selection, auto-scan and winner display.
module vote_display_ctrl
    import vote_pkg::*;
#(
    parameter int N_CAND      = 4,
    parameter int VOTE_W      = 8,
    parameter int ACK_CYCLES  = 100000000,
    parameter int SCAN_CYCLES = 100000000,
    parameter int IDX_W       = $clog2(N_CAND)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               mode,
    input  logic                     valid_vote_casted,
    input  logic [N_CAND*VOTE_W-1:0] vote_counts,
    input  logic [N_CAND-1:0]        button_press,
    output logic [VOTE_W-1:0]        leds,
    output logic [IDX_W-1:0]         disp_idx,
    output logic [IDX_W-1:0]         winner_idx,
    output logic                     winner_valid,
    output logic                     tie
);

    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_CYCLES);
    localparam logic [TMR_W-1:0] SCAN_LAST = TMR_W'(SCAN_CYCLES - 1);

    logic [VOTE_W-1:0] cnt_s [N_CAND];
    logic [VOTE_W-1:0] tie_mask_s;
    mode_e             mode_s;
    mode_e             mode_prev_r;
    logic [TMR_W-1:0]  ack_cnt_r;
    logic [TMR_W-1:0]  scan_tmr_r;
    logic [IDX_W-1:0]  scan_idx_r;
    logic              blink_r;
    logic [IDX_W-1:0]  sel_idx_r;
    logic              entering_s;
    logic [TMR_W-1:0]  scan_tmr_cur_s;
    logic [IDX_W-1:0]  scan_idx_cur_s;
    logic              blink_cur_s;
    logic              scan_tc_s;
    logic [IDX_W-1:0]  sel_nxt_s;
    logic [VOTE_W-1:0] leds_nxt_s;
    logic [IDX_W-1:0]  disp_nxt_s;

    genvar g;
    generate
        for (g = 0; g < N_CAND; g++) begin : g_unpack
            assign cnt_s[g] = vote_counts[g*VOTE_W +: VOTE_W];
        end
        for (g = 0; g < VOTE_W; g++) begin : g_mask
            assign tie_mask_s[g] = TIE_PATTERN[g % 8];
        end
    endgenerate

    assign mode_s = mode_e'(mode);

    winner_scan #(
        .N_CAND (N_CAND),
        .VOTE_W (VOTE_W),
        .IDX_W  (IDX_W)
    ) u_winner_scan (
        .clock        (clock),
        .reset_n      (reset_n),
        .vote_counts  (vote_counts),
        .winner_idx   (winner_idx),
        .tie          (tie),
        .winner_valid (winner_valid)
    );

    // Entering SCAN or WINNER restarts the shared interval timer, scan index and tie blink phase.
    always_comb begin
        entering_s     = (mode_s != mode_prev_r) &&
                         ((mode_s == MODE_SCAN) || (mode_s == MODE_WINNER));
        scan_tmr_cur_s = entering_s ? {TMR_W{1'b0}} : scan_tmr_r;
        scan_idx_cur_s = entering_s ? {IDX_W{1'b0}} : scan_idx_r;
        blink_cur_s    = entering_s ? 1'b0 : blink_r;
        scan_tc_s      = (scan_tmr_cur_s >= SCAN_LAST);
    end

    // Lowest-index pressed button wins; descending loop lets it overwrite higher ones.
    always_comb begin
        sel_nxt_s = sel_idx_r;
        if (mode_s == MODE_MANUAL) begin
            for (int i = N_CAND - 1; i >= 0; i--) begin
                if (button_press[i]) begin
                    sel_nxt_s = IDX_W'(i);
                end
            end
        end else begin
            sel_nxt_s = sel_idx_r;
        end
    end

    // Output mux feeding the registered LED and index outputs.
    always_comb begin
        leds_nxt_s = {VOTE_W{1'b0}};
        disp_nxt_s = {IDX_W{1'b0}};
        case (mode_s)
            MODE_VOTING: begin
                leds_nxt_s = (ack_cnt_r != {TMR_W{1'b0}}) ? {VOTE_W{1'b1}} : {VOTE_W{1'b0}};
                disp_nxt_s = {IDX_W{1'b0}};
            end
            MODE_MANUAL: begin
                leds_nxt_s = cnt_s[sel_nxt_s];
                disp_nxt_s = sel_nxt_s;
            end
            MODE_SCAN: begin
                leds_nxt_s = cnt_s[scan_idx_cur_s];
                disp_nxt_s = scan_idx_cur_s;
            end
            MODE_WINNER: begin
                leds_nxt_s = cnt_s[winner_idx] ^
                             ((tie && blink_cur_s) ? tie_mask_s : {VOTE_W{1'b0}});
                disp_nxt_s = winner_idx;
            end
            default: begin
                leds_nxt_s = {VOTE_W{1'b0}};
                disp_nxt_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Timers, selection and scan state plus registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_prev_r <= MODE_VOTING;
            ack_cnt_r   <= {TMR_W{1'b0}};
            scan_tmr_r  <= {TMR_W{1'b0}};
            scan_idx_r  <= {IDX_W{1'b0}};
            blink_r     <= 1'b0;
            sel_idx_r   <= {IDX_W{1'b0}};
            leds        <= {VOTE_W{1'b0}};
            disp_idx    <= {IDX_W{1'b0}};
        end else begin
            mode_prev_r <= mode_s;
            if (valid_vote_casted) begin
                ack_cnt_r <= ACK_LOAD;
            end else if (ack_cnt_r != {TMR_W{1'b0}}) begin
                ack_cnt_r <= ack_cnt_r - TMR_W'(1);
            end
            if (scan_tc_s) begin
                scan_tmr_r <= {TMR_W{1'b0}};
                scan_idx_r <= (scan_idx_cur_s == IDX_W'(N_CAND - 1)) ?
                              {IDX_W{1'b0}} : scan_idx_cur_s + IDX_W'(1);
                blink_r    <= ~blink_cur_s;
            end else begin
                scan_tmr_r <= scan_tmr_cur_s + TMR_W'(1);
                scan_idx_r <= scan_idx_cur_s;
                blink_r    <= blink_cur_s;
            end
            sel_idx_r <= sel_nxt_s;
            leds      <= leds_nxt_s;
            disp_idx  <= disp_nxt_s;
        end
    end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Directed self-checking bench for vote_display_ctrl (N_CAND=4, VOTE_W=8,
// ACK_CYCLES=10, SCAN_CYCLES=4).
module tb_vote_display_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic        valid_vote_casted;
    logic [31:0] vote_counts;
    logic [3:0]  button_press;
    logic [7:0]  leds;
    logic [1:0]  disp_idx;
    logic [1:0]  winner_idx;
    logic        winner_valid;
    logic        tie;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  btn;
        logic [31:0] counts;
        logic [7:0]  exp_leds;
        logic [1:0]  exp_disp;
    } vec_t;

    vec_t tbl [10];

    vote_display_ctrl #(
        .N_CAND      (4),
        .VOTE_W      (8),
        .ACK_CYCLES  (10),
        .SCAN_CYCLES (4)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mode              (mode),
        .valid_vote_casted (valid_vote_casted),
        .vote_counts       (vote_counts),
        .button_press      (button_press),
        .leds              (leds),
        .disp_idx          (disp_idx),
        .winner_idx        (winner_idx),
        .winner_valid      (winner_valid),
        .tie               (tie)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_winner(input logic [1:0] exp_idx, input logic exp_tie, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 9 && !ok; n++) begin
            step();
            if (winner_valid && winner_idx == exp_idx && tie == exp_tie) ok = 1'b1;
        end
        chk(name, {29'd0, winner_idx, tie}, {29'd0, exp_idx, exp_tie});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] scan_cnt [4];
        scan_cnt = '{8'd3, 8'd8, 8'd1, 8'd9};

        tbl[0] = '{2'd1, 4'b0000, 32'h09010703, 8'h03, 2'd0};
        tbl[1] = '{2'd1, 4'b1010, 32'h09010703, 8'h07, 2'd1};
        tbl[2] = '{2'd1, 4'b0000, 32'h09010703, 8'h07, 2'd1};
        tbl[3] = '{2'd1, 4'b0000, 32'h09010803, 8'h08, 2'd1};
        tbl[4] = '{2'd1, 4'b1000, 32'h09010803, 8'h09, 2'd3};
        tbl[5] = '{2'd1, 4'b0100, 32'h09010803, 8'h01, 2'd2};
        tbl[6] = '{2'd1, 4'b1111, 32'h09010803, 8'h03, 2'd0};
        tbl[7] = '{2'd1, 4'b0010, 32'h09010803, 8'h08, 2'd1};
        tbl[8] = '{2'd0, 4'b0000, 32'h09010803, 8'h00, 2'd0};
        tbl[9] = '{2'd1, 4'b0000, 32'h09010803, 8'h08, 2'd1};

        // Reset with a vote pulse held during reset
        reset_n           = 1'b0;
        mode              = 2'd0;
        valid_vote_casted = 1'b1;
        vote_counts       = 32'h0;
        button_press      = 4'b0;
        step();
        step();
        chk("rst_leds", {24'd0, leds}, 32'h0);
        chk("rst_disp", {30'd0, disp_idx}, 32'h0);
        chk("rst_widx", {30'd0, winner_idx}, 32'h0);
        chk("rst_wvalid", {31'd0, winner_valid}, 32'h0);
        chk("rst_tie", {31'd0, tie}, 32'h0);
        valid_vote_casted = 1'b0;
        reset_n           = 1'b1;
        step();
        chk("vote_in_reset_ignored", {24'd0, leds}, 32'h0);
        step();
        step();
        chk("wvalid_before_pass", {31'd0, winner_valid}, 32'h0);
        step();
        chk("wvalid_after_pass", {31'd0, winner_valid}, 32'h1);
        chk("zero_widx", {30'd0, winner_idx}, 32'h0);
        chk("zero_tie", {31'd0, tie}, 32'h0);

        // Single acknowledge flash: 10 cycles of all ones
        valid_vote_casted = 1'b1;
        step();
        valid_vote_casted = 1'b0;
        chk("ack_edge_k", {24'd0, leds}, 32'h0);
        for (int j = 1; j <= 10; j++) begin
            step();
            chk($sformatf("ack_on_%0d", j), {24'd0, leds}, 32'hFF);
        end
        step();
        chk("ack_off", {24'd0, leds}, 32'h0);

        // Retrigger at cycle 5 extends the flash to cycle 15
        valid_vote_casted = 1'b1;
        step();
        valid_vote_casted = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            valid_vote_casted = (j == 5);
            step();
            valid_vote_casted = 1'b0;
            chk($sformatf("retrig_on_%0d", j), {24'd0, leds}, 32'hFF);
        end
        step();
        chk("retrig_off", {24'd0, leds}, 32'h0);

        // Manual selection vectors
        for (int i = 0; i < 10; i++) begin
            mode         = tbl[i].mode;
            button_press = tbl[i].btn;
            vote_counts  = tbl[i].counts;
            step();
            chk($sformatf("tbl%0d_leds", i), {24'd0, leds}, {24'd0, tbl[i].exp_leds});
            chk($sformatf("tbl%0d_disp", i), {30'd0, disp_idx}, {30'd0, tbl[i].exp_disp});
        end
        button_press = 4'b0;

        // Auto-scan: index changes every 4 clocks and wraps
        mode = 2'd2;
        for (int j = 0; j < 20; j++) begin
            step();
            chk($sformatf("scan_disp_%0d", j), {30'd0, disp_idx}, (j / 4) % 4);
            chk($sformatf("scan_leds_%0d", j), {24'd0, leds}, {24'd0, scan_cnt[(j / 4) % 4]});
        end
        mode = 2'd1;
        step();
        mode = 2'd2;
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("rescan_disp_%0d", j), {30'd0, disp_idx}, (j / 4) % 4);
        end

        // Winner with a tie between candidates 1 and 2
        mode        = 2'd1;
        vote_counts = 32'h01050502;
        wait_winner(2'd1, 1'b1, "tie_winner");
        mode = 2'd3;
        for (int j = 0; j < 12; j++) begin
            step();
            chk($sformatf("tie_leds_%0d", j), {24'd0, leds}, ((j / 4) % 2) ? 32'hAF : 32'h05);
            chk($sformatf("tie_disp_%0d", j), {30'd0, disp_idx}, 32'h1);
        end
        vote_counts = 32'h01050506;
        wait_winner(2'd0, 1'b0, "new_winner");
        step();
        chk("win_leds", {24'd0, leds}, 32'h06);
        chk("win_disp", {30'd0, disp_idx}, 32'h0);

        // All zero counts: no tie, candidate 0
        vote_counts = 32'h0;
        wait_winner(2'd0, 1'b0, "all_zero");

        // Reset mid-flash and mid-pass
        vote_counts = 32'h00070000;
        wait_winner(2'd2, 1'b0, "pre_reset_winner");
        mode              = 2'd0;
        valid_vote_casted = 1'b1;
        step();
        valid_vote_casted = 1'b0;
        step();
        step();
        chk("midflash_leds", {24'd0, leds}, 32'hFF);
        reset_n = 1'b0;
        #1;
        chk("async_rst_leds", {24'd0, leds}, 32'h0);
        chk("async_rst_widx", {30'd0, winner_idx}, 32'h0);
        chk("async_rst_wvalid", {31'd0, winner_valid}, 32'h0);
        chk("async_rst_disp", {30'd0, disp_idx}, 32'h0);
        chk("async_rst_tie", {31'd0, tie}, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        chk("post_rst_wvalid_low", {31'd0, winner_valid}, 32'h0);
        chk("post_rst_leds", {24'd0, leds}, 32'h0);
        step();
        chk("post_rst_wvalid_high", {31'd0, winner_valid}, 32'h1);
        chk("post_rst_widx", {30'd0, winner_idx}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
